// File: rtl/regfile_mp_if.sv
// Register-file port bundle: two read ports, one write port and bulk-clear control.
// master = decode/writeback side, slave = the register file.
interface regfile_mp_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic [ADDR_W-1:0] rd_addr1;
  logic [ADDR_W-1:0] rd_addr2;
  logic [DATA_W-1:0] rd_data1;
  logic [DATA_W-1:0] rd_data2;
  logic              rd_err1;
  logic              rd_err2;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_ready;
  logic              wr_err;
  logic              clr_req;
  logic              clr_busy;
  logic              clr_done;

  modport master (
    output rd_addr1, rd_addr2, wr_en, wr_addr, wr_data, clr_req,
    input  rd_data1, rd_data2, rd_err1, rd_err2, wr_ready, wr_err, clr_busy, clr_done
  );

  modport slave (
    input  rd_addr1, rd_addr2, wr_en, wr_addr, wr_data, clr_req,
    output rd_data1, rd_data2, rd_err1, rd_err2, wr_ready, wr_err, clr_busy, clr_done
  );
endinterface

// File: rtl/regfile_mp.sv
// Two combinational read ports with optional same-cycle bypass, one synchronous write port.
// Writes stall (wr_ready low) while the one-entry-per-cycle bulk clear runs; dropped writes pulse wr_err.
module regfile_mp #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_REGS = 32,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input logic         clk,
  input logic         rst,
  regfile_mp_if.slave bus
);

  localparam int IDX_W = $clog2(NUM_REGS) + 1;

  if (NUM_REGS < 2 || NUM_REGS > (1 << ADDR_W)) begin : gBadNumRegs
    $error("regfile_mp: NUM_REGS out of range for ADDR_W");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    DONE  = 2'd2
  } clrState_t;

  clrState_t         state;
  clrState_t         nextState;
  logic [IDX_W-1:0]  clrIdx;
  logic [DATA_W-1:0] regs [NUM_REGS];

  logic              wrReady;
  logic              clrBusy;
  logic              clrDone;
  logic              wrInRange;
  logic              wrToZero;
  logic              wrAccept;
  logic              wrDrop;
  logic              wrErrQ;
  logic              clrWrite;
  logic              clrLast;

  logic              rdInRange1;
  logic              rdInRange2;
  logic [DATA_W-1:0] stored1;
  logic [DATA_W-1:0] stored2;
  logic [DATA_W-1:0] rdData1;
  logic [DATA_W-1:0] rdData2;

  // Widen by one bit so NUM_REGS == 2**ADDR_W still compares correctly.
  assign wrInRange  = {1'b0, bus.wr_addr}  < (ADDR_W+1)'(NUM_REGS);
  assign rdInRange1 = {1'b0, bus.rd_addr1} < (ADDR_W+1)'(NUM_REGS);
  assign rdInRange2 = {1'b0, bus.rd_addr2} < (ADDR_W+1)'(NUM_REGS);

  assign wrToZero = (ZERO_REG != 0) && (bus.wr_addr == '0);
  assign wrAccept = bus.wr_en && wrReady && wrInRange && !wrToZero;
  assign wrDrop   = bus.wr_en && (!wrReady || !wrInRange);

  assign clrWrite = (state == CLEAR);
  assign clrLast  = (clrIdx == IDX_W'(NUM_REGS - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  always_comb begin
    nextState = state;
    wrReady   = 1'b1;
    clrBusy   = 1'b0;
    clrDone   = 1'b0;
    case (state)
      IDLE: begin
        if (bus.clr_req) nextState = CLEAR;
      end
      CLEAR: begin
        wrReady = 1'b0;
        clrBusy = 1'b1;
        if (clrLast) nextState = DONE;
      end
      DONE: begin
        clrDone   = 1'b1;
        nextState = IDLE;
      end
      default: nextState = IDLE;
    endcase
  end

  // Index saturates at the last entry; the state change to DONE ends the sweep.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clrIdx <= '0;
    end else if (state == IDLE && bus.clr_req) begin
      clrIdx <= '0;
    end else if (state == CLEAR && !clrLast) begin
      clrIdx <= clrIdx + IDX_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (clrWrite && clrIdx == IDX_W'(i)) begin
          regs[i] <= '0;
        end else if (wrAccept && bus.wr_addr == ADDR_W'(i)) begin
          regs[i] <= bus.wr_data;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrErrQ <= 1'b0;
    end else begin
      wrErrQ <= wrDrop;
    end
  end

  // Decoded mux over implemented entries only; unmatched addresses fall to zero.
  always_comb begin
    stored1 = '0;
    stored2 = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (bus.rd_addr1 == ADDR_W'(i)) stored1 = regs[i];
      if (bus.rd_addr2 == ADDR_W'(i)) stored2 = regs[i];
    end
  end

  always_comb begin
    rdData1 = stored1;
    if (!rdInRange1) begin
      rdData1 = '0;
    end else if ((ZERO_REG != 0) && bus.rd_addr1 == '0) begin
      rdData1 = '0;
    end else if ((BYPASS != 0) && wrAccept && bus.wr_addr == bus.rd_addr1) begin
      rdData1 = bus.wr_data;
    end
  end

  always_comb begin
    rdData2 = stored2;
    if (!rdInRange2) begin
      rdData2 = '0;
    end else if ((ZERO_REG != 0) && bus.rd_addr2 == '0) begin
      rdData2 = '0;
    end else if ((BYPASS != 0) && wrAccept && bus.wr_addr == bus.rd_addr2) begin
      rdData2 = bus.wr_data;
    end
  end

  assign bus.rd_data1 = rdData1;
  assign bus.rd_data2 = rdData2;
  assign bus.rd_err1  = !rdInRange1;
  assign bus.rd_err2  = !rdInRange2;
  assign bus.wr_ready = wrReady;
  assign bus.wr_err   = wrErrQ;
  assign bus.clr_busy = clrBusy;
  assign bus.clr_done = clrDone;

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench: dutA is the default 32-entry file, dutB has 24 entries, no zero register, no bypass.
module tb_regfile_mp;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  regfile_mp_if #(.DATA_W(32), .ADDR_W(5)) busA ();
  regfile_mp_if #(.DATA_W(32), .ADDR_W(5)) busB ();

  regfile_mp #(.DATA_W(32), .ADDR_W(5), .NUM_REGS(32), .ZERO_REG(1), .BYPASS(1)) dutA (
    .clk (clk),
    .rst (rst),
    .bus (busA)
  );

  regfile_mp #(.DATA_W(32), .ADDR_W(5), .NUM_REGS(24), .ZERO_REG(0), .BYPASS(0)) dutB (
    .clk (clk),
    .rst (rst),
    .bus (busB)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int busyCnt;
    int doneCnt;
    int doneAt;
    logic [31:0] orAcc;

    checks = 0;
    errors = 0;
    rst = 1'b1;
    busA.rd_addr1 = '0; busA.rd_addr2 = '0; busA.wr_en = 1'b0;
    busA.wr_addr = '0;  busA.wr_data = '0;  busA.clr_req = 1'b0;
    busB.rd_addr1 = '0; busB.rd_addr2 = '0; busB.wr_en = 1'b0;
    busB.wr_addr = '0;  busB.wr_data = '0;  busB.clr_req = 1'b0;

    // Reset state
    #12;
    busA.rd_addr1 = 5'd5;
    #1;
    chk("rst_clr_busy", busA.clr_busy, 1'b0);
    chk("rst_clr_done", busA.clr_done, 1'b0);
    chk("rst_wr_err", busA.wr_err, 1'b0);
    chk("rst_r5", busA.rd_data1, 32'h0);
    rst = 1'b0;
    step();
    chk("rst_wr_ready", busA.wr_ready, 1'b1);

    // 1: write r5, read back on both ports
    busA.wr_en = 1'b1; busA.wr_addr = 5'd5; busA.wr_data = 32'hDEADBEEF;
    step();
    busA.wr_en = 1'b0; busA.rd_addr1 = 5'd5; busA.rd_addr2 = 5'd5;
    #1;
    chk("wr_r5_port1", busA.rd_data1, 32'hDEADBEEF);
    chk("wr_r5_port2", busA.rd_data2, 32'hDEADBEEF);
    chk("wr_r5_err1", busA.rd_err1, 1'b0);
    chk("wr_r5_err2", busA.rd_err2, 1'b0);

    // 2: same-cycle bypass vs no bypass
    busA.wr_en = 1'b1; busA.wr_addr = 5'd7; busA.wr_data = 32'h12345678; busA.rd_addr1 = 5'd7;
    busB.wr_en = 1'b1; busB.wr_addr = 5'd7; busB.wr_data = 32'h12345678; busB.rd_addr1 = 5'd7;
    #1;
    chk("bypass_on", busA.rd_data1, 32'h12345678);
    chk("bypass_off_old", busB.rd_data1, 32'h0);
    step();
    busA.wr_en = 1'b0; busB.wr_en = 1'b0;
    #1;
    chk("bypass_off_next", busB.rd_data1, 32'h12345678);
    chk("bypass_on_stored", busA.rd_data1, 32'h12345678);

    // 3: zero register
    busA.wr_en = 1'b1; busA.wr_addr = 5'd0; busA.wr_data = 32'hFFFFFFFF; busA.rd_addr1 = 5'd0;
    busB.wr_en = 1'b1; busB.wr_addr = 5'd0; busB.wr_data = 32'hFFFFFFFF; busB.rd_addr1 = 5'd0;
    #1;
    chk("zero_no_bypass", busA.rd_data1, 32'h0);
    step();
    busA.wr_en = 1'b0; busB.wr_en = 1'b0;
    #1;
    chk("zero_r0", busA.rd_data1, 32'h0);
    chk("zero_wr_err", busA.wr_err, 1'b0);
    chk("nozero_r0", busB.rd_data1, 32'hFFFFFFFF);

    // 4: out-of-range with 24 entries
    busB.rd_addr1 = 5'd30; busB.rd_addr2 = 5'd23;
    #1;
    chk("oor_rd_data", busB.rd_data1, 32'h0);
    chk("oor_rd_err", busB.rd_err1, 1'b1);
    chk("last_in_range_err", busB.rd_err2, 1'b0);
    busB.rd_addr2 = 5'd24;
    #1;
    chk("first_oor_err", busB.rd_err2, 1'b1);
    busB.wr_en = 1'b1; busB.wr_addr = 5'd30; busB.wr_data = 32'hAAAA5555;
    busB.rd_addr1 = 5'd7; busB.rd_addr2 = 5'd0;
    step();
    busB.wr_en = 1'b0;
    #1;
    chk("oor_wr_err", busB.wr_err, 1'b1);
    chk("oor_r7_kept", busB.rd_data1, 32'h12345678);
    chk("oor_r0_kept", busB.rd_data2, 32'hFFFFFFFF);
    step();
    chk("oor_wr_err_pulse", busB.wr_err, 1'b0);

    // 5: fill r1..r31 with index*3, then bulk clear
    for (int i = 1; i < 32; i++) begin
      busA.wr_en = 1'b1; busA.wr_addr = 5'(i); busA.wr_data = 32'(i * 3);
      step();
    end
    busA.wr_en = 1'b0; busA.rd_addr1 = 5'd31; busA.rd_addr2 = 5'd1;
    #1;
    chk("fill_r31", busA.rd_data1, 32'd93);
    chk("fill_r1", busA.rd_data2, 32'd3);

    busA.clr_req = 1'b1;
    step();
    busA.clr_req = 1'b0;
    busyCnt = 0; doneCnt = 0; doneAt = -1;
    for (int c = 0; c < 40; c++) begin
      busA.clr_req = (c == 3 || c == 32);
      if (c == 6) chk("midclear_wr_err", busA.wr_err, 1'b1);
      if (c == 10) begin
        busA.rd_addr1 = 5'd9; busA.rd_addr2 = 5'd10;
        #1;
        chk("clr_partial_lo", busA.rd_data1, 32'h0);
        chk("clr_partial_hi", busA.rd_data2, 32'd30);
      end
      if (c == 5) begin
        chk("midclear_wr_ready", busA.wr_ready, 1'b0);
        busA.wr_en = 1'b1; busA.wr_addr = 5'd31; busA.wr_data = 32'h77;
      end else begin
        busA.wr_en = 1'b0;
      end
      if (busA.clr_busy) busyCnt++;
      if (busA.clr_done) begin
        doneCnt++;
        doneAt = c;
      end
      step();
    end
    busA.clr_req = 1'b0;
    busA.wr_en = 1'b0;
    chk("clr_busy_cycles", busyCnt, 32);
    chk("clr_done_count", doneCnt, 1);
    chk("clr_done_cycle", doneAt, 32);

    orAcc = '0;
    for (int i = 0; i < 32; i++) begin
      busA.rd_addr1 = 5'(i); busA.rd_addr2 = 5'(31 - i);
      #1;
      orAcc = orAcc | busA.rd_data1 | busA.rd_data2;
    end
    chk("all_zero_after_clear", orAcc, 32'h0);

    // 6: reset 10 cycles into a clear
    step();
    busA.wr_en = 1'b1; busA.wr_addr = 5'd20; busA.wr_data = 32'h2020;
    step();
    busA.wr_addr = 5'd3; busA.wr_data = 32'h33;
    step();
    busA.wr_en = 1'b0; busA.clr_req = 1'b1;
    step();
    busA.clr_req = 1'b0;
    for (int c = 0; c < 10; c++) step();
    chk("preclr_busy", busA.clr_busy, 1'b1);
    rst = 1'b1;
    busA.rd_addr1 = 5'd20; busA.rd_addr2 = 5'd3;
    #1;
    chk("rst_midclr_busy", busA.clr_busy, 1'b0);
    chk("rst_midclr_r20", busA.rd_data1, 32'h0);
    chk("rst_midclr_r3", busA.rd_data2, 32'h0);
    #1;
    rst = 1'b0;
    busA.wr_en = 1'b1; busA.wr_addr = 5'd12; busA.wr_data = 32'hC0FFEE;
    doneCnt = 0;
    if (busA.clr_done) doneCnt++;
    step();
    busA.wr_en = 1'b0; busA.rd_addr1 = 5'd12;
    #1;
    chk("postrst_write", busA.rd_data1, 32'hC0FFEE);
    chk("postrst_wr_err", busA.wr_err, 1'b0);
    for (int c = 0; c < 5; c++) begin
      if (busA.clr_done || busA.clr_busy) doneCnt++;
      step();
    end
    chk("postrst_no_done", doneCnt, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
Parametrised multi-read register file, the successor to the fixed 32x32 register bank in the KGP_RISC datapath. It provides two combinational read ports and one synchronous write port. It adds a hardwired zero register, same-cycle write-to-read bypass, and out-of-range detection. A sequenced bulk-clear engine zeroes the array one entry per cycle without asserting reset. It sits between decode (read addresses) and writeback (write port) in the core.

Parameters:
DATA_W, 32, data width in bits
ADDR_W, 5, address width in bits
NUM_REGS, 32, number of implemented entries; must satisfy 2 <= NUM_REGS <= 2**ADDR_W
ZERO_REG, 1, 1 = entry 0 always reads 0 and ignores writes
BYPASS, 1, 1 = an accepted write in the current cycle is forwarded to matching read ports

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
rd_addr1  in  ADDR_W  read port 1 address
rd_addr2  in  ADDR_W  read port 2 address
rd_data1  out  DATA_W  read port 1 data, combinational
rd_data2  out  DATA_W  read port 2 data, combinational
rd_err1  out  1  rd_addr1 >= NUM_REGS, combinational
rd_err2  out  1  rd_addr2 >= NUM_REGS, combinational
wr_en  in  1  write request
wr_addr  in  ADDR_W  write address
wr_data  in  DATA_W  write data
wr_ready  out  1  write port accepting; low while clear engine busy
wr_err  out  1  registered 1-cycle pulse: previous-cycle write was dropped
clr_req  in  1  start bulk clear (level sampled in IDLE)
clr_busy  out  1  clear engine active
clr_done  out  1  1-cycle pulse when clear completes

Behaviour:
- Reset (async): all entries = 0; FSM = IDLE; clr_busy=0, clr_done=0, wr_err=0; wr_ready=1 after reset deasserts.
- Write acceptance: accept = wr_en & wr_ready & (wr_addr < NUM_REGS) & !(ZERO_REG & wr_addr==0). An accepted write updates the entry at the rising edge.
- wr_err=1 the cycle after wr_en=1 was dropped. Causes: wr_ready=0, or wr_addr >= NUM_REGS. A write to entry 0 with ZERO_REG=1 is silently ignored and does not raise wr_err.
- Read, per port: if addr >= NUM_REGS, data=0 and err=1.
  - Else if ZERO_REG and addr==0, data=0.
  - Else if BYPASS and accept and wr_addr==addr, data=wr_data.
  - Else data = stored entry.
  - Zero latency, combinational; no X ever driven.
- Clear FSM states: IDLE, CLEAR, DONE.
  - IDLE: clr_busy=0, wr_ready=1. clr_req=1 at an edge -> CLEAR, index counter = 0.
  - CLEAR: clr_busy=1, wr_ready=0. Each edge writes 0 to entry[index], then index++. At the edge where index==NUM_REGS-1 -> DONE.
  - DONE: clr_busy=0, clr_done=1, wr_ready=1; next edge -> IDLE.
- Clear latency: clr_req sampled at edge T. clr_busy is high for cycles T+1..T+NUM_REGS. clr_done is high in cycle T+NUM_REGS+1.
- Reads during CLEAR return current array contents: entries below index read 0, the rest read their old values. Bypass is inactive during CLEAR because no write is accepted.
- clr_req in CLEAR or DONE: ignored, not queued.
- clr_req and an accepted wr_en at the same edge in IDLE: the write commits, then the clear overwrites it.
- rst mid-clear: immediate return to IDLE with all entries 0; no clr_done pulse.
- Index counter width: clog2(NUM_REGS)+1 bits; no wrap-around beyond NUM_REGS-1.

Test Plan:
1. Reset, then write 0xDEADBEEF to r5 and read r5 on both ports the next cycle -> both rd_data = 0xDEADBEEF, rd_err = 0.
2. Same-cycle bypass: wr_en=1, wr_addr=7, wr_data=0x12345678, rd_addr1=7 -> rd_data1=0x12345678 in that cycle. Repeat with BYPASS=0 -> old value (0) until the next cycle.
3. Zero register: write 0xFFFFFFFF to r0 -> r0 reads 0 and wr_err stays 0. With ZERO_REG=0, r0 reads 0xFFFFFFFF.
4. Out-of-range, NUM_REGS=24: rd_addr1=30 -> rd_data1=0, rd_err1=1. Write to addr 30 -> wr_err=1 the next cycle and no entry changes.
5. Bulk clear: fill r1..r31 with value index*3, pulse clr_req.
   - clr_busy is high for exactly 32 cycles and clr_done pulses once.
   - A write issued mid-clear is dropped with wr_err=1.
   - All entries read 0 afterwards.
6. Assert rst 10 cycles into a clear -> clr_busy=0 immediately, no clr_done, all entries 0, and a write accepted on the first post-reset cycle.
